// File: rtl/sid_pkg.sv
// sid_pkg: constants and types shared by the SID read-side logic.
//   ADDR_POTX/ADDR_POTY/ADDR_OSC3/ADDR_ENV3 - read-only register addresses.
//   pot_state_e                            - pot measurement FSM state.
package sid_pkg;

  localparam logic [4:0] ADDR_POTX = 5'h19;
  localparam logic [4:0] ADDR_POTY = 5'h1A;
  localparam logic [4:0] ADDR_OSC3 = 5'h1B;
  localparam logic [4:0] ADDR_ENV3 = 5'h1C;

  typedef enum logic {
    DISCHARGE = 1'b0,
    COUNT     = 1'b1
  } pot_state_e;

endpackage

// File: rtl/sid_pot_axis.sv
// sid_pot_axis: one paddle axis of the pot measurement.
//   clk, rst   - master clock, asynchronous active-high reset.
//   pot_i      - asynchronous comparator output (1 = capacitor above threshold).
//   clear_i    - held high while capacitors discharge; clears count and stop flag.
//   tick_i     - one count tick (clkEn while counting).
//   publish_i  - last tick of the count phase; only ever asserted with tick_i.
//   value_o    - published count, read back as POTX/POTY.
module sid_pot_axis
  import sid_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pot_i,
  input  logic       clear_i,
  input  logic       tick_i,
  input  logic       publish_i,
  output logic [7:0] value_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       stop_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] pub_q;

  // Count value after the current tick; also what gets published so the
  // final tick of the phase is included in the result.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q && !stop_q && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      stop_q  <= 1'b0;
      cnt_q   <= 8'h00;
      pub_q   <= 8'h00;
    end else begin
      sync1_q <= pot_i;
      sync2_q <= sync1_q;
      if (clear_i) begin
        cnt_q  <= 8'h00;
        stop_q <= 1'b0;
      end else if (tick_i) begin
        cnt_q <= cnt_d;
        // Once the capacitor has crossed the threshold the count freezes,
        // even if the comparator chatters back to 0 later.
        if (sync2_q) begin
          stop_q <= 1'b1;
        end
      end
      if (publish_i) begin
        pub_q <= cnt_d;
      end
    end
  end

  assign value_o = pub_q;

endmodule

// File: rtl/sid_readback.sv
// sid_readback: read-side bus responder for the SID register space.
//   clk, rst        - master clock, asynchronous active-high reset.
//   clkEn           - 1 MHz tick enable (pot FSM and bus-latch decay).
//   iRE, iWE        - read / write strobes, one clk wide.
//   iAddr           - register address.
//   iDataW          - write data (loaded into the bus latch).
//   iOsc3, iEnv3    - voice-2 oscillator and envelope.
//   iPotX, iPotY    - asynchronous pot comparator outputs.
//   oDataR          - read data.
//   oPotDischarge   - high while the pot capacitors are discharged.
//   oDbgState       - current pot FSM state, for observation only.
//
// Bus protocol: a read is serviced on the clk edge where iRE=1 and iWE=0;
// oDataR carries the result from the next cycle and holds until the next
// serviced read. There is no backpressure. iWE always wins over iRE.
module sid_readback
  import sid_pkg::*;
#(
  parameter int DECAY_TICKS = 8192,
  parameter int POT_HALF    = 256   // must not exceed 256 (8-bit phase counter)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clkEn,
  input  logic        iRE,
  input  logic        iWE,
  input  logic [4:0]  iAddr,
  input  logic [7:0]  iDataW,
  input  logic [11:0] iOsc3,
  input  logic [7:0]  iEnv3,
  input  logic        iPotX,
  input  logic        iPotY,
  output logic [7:0]  oDataR,
  output logic        oPotDischarge,
  output pot_state_e  oDbgState
);

  localparam int              DW         = $clog2(DECAY_TICKS + 1);
  localparam logic [DW-1:0]   DECAY_END  = DW'(DECAY_TICKS);
  localparam logic [DW-1:0]   DECAY_PRE  = DW'(DECAY_TICKS - 1);
  localparam logic [7:0]      PHASE_LAST = 8'(POT_HALF - 1);

  pot_state_e      state_q;
  logic [7:0]      phase_q;
  logic            disch_q;
  logic [7:0]      rdata_q;
  logic [7:0]      rdata_d;
  logic [7:0]      latch_q;
  logic [DW-1:0]   decay_q;
  logic [7:0]      potx;
  logic [7:0]      poty;
  logic            pot_clear;
  logic            pot_tick;
  logic            pot_publish;
  logic            unused_osc_lo;

  // OSC3 only exposes the top byte of the waveform.
  assign unused_osc_lo = ^iOsc3[3:0];

  assign pot_clear   = (state_q == DISCHARGE);
  assign pot_tick    = clkEn && (state_q == COUNT);
  assign pot_publish = pot_tick && (phase_q == PHASE_LAST);

  sid_pot_axis u_pot_x (
    .clk       (clk),
    .rst       (rst),
    .pot_i     (iPotX),
    .clear_i   (pot_clear),
    .tick_i    (pot_tick),
    .publish_i (pot_publish),
    .value_o   (potx)
  );

  sid_pot_axis u_pot_y (
    .clk       (clk),
    .rst       (rst),
    .pot_i     (iPotY),
    .clear_i   (pot_clear),
    .tick_i    (pot_tick),
    .publish_i (pot_publish),
    .value_o   (poty)
  );

  // Pot FSM: each state lasts POT_HALF ticks; the phase counter restarts at
  // the same edge as the state change so no tick is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DISCHARGE;
      phase_q <= 8'h00;
      disch_q <= 1'b1;
    end else if (clkEn) begin
      if (phase_q == PHASE_LAST) begin
        phase_q <= 8'h00;
        case (state_q)
          DISCHARGE: begin
            state_q <= COUNT;
            disch_q <= 1'b0;
          end
          default: begin
            state_q <= DISCHARGE;
            disch_q <= 1'b1;
          end
        endcase
      end else begin
        phase_q <= phase_q + 8'd1;
      end
    end
  end

  // Read mux; published pot values are registers, so a read on the publish
  // edge naturally returns the previous measurement.
  always_comb begin
    rdata_d = latch_q;
    case (iAddr)
      ADDR_POTX: rdata_d = potx;
      ADDR_POTY: rdata_d = poty;
      ADDR_OSC3: rdata_d = iOsc3[11:4];
      ADDR_ENV3: rdata_d = iEnv3;
      default:   rdata_d = latch_q;
    endcase
  end

  // Bus latch with decay. Any load (write or serviced read) restarts the
  // decay count and takes priority over expiry on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 8'h00;
      latch_q <= 8'h00;
      decay_q <= '0;
    end else begin
      if (iWE) begin
        latch_q <= iDataW;
        decay_q <= '0;
      end else if (iRE) begin
        rdata_q <= rdata_d;
        latch_q <= rdata_d;
        decay_q <= '0;
      end else if (clkEn && (decay_q != DECAY_END)) begin
        decay_q <= decay_q + DW'(1);
        if (decay_q == DECAY_PRE) begin
          latch_q <= 8'h00;
        end
      end
    end
  end

  assign oDataR        = rdata_q;
  assign oPotDischarge = disch_q;
  assign oDbgState     = state_q;

endmodule

// File: tb/tb_sid_readback.sv
module tb_sid_readback;
  import sid_pkg::*;

  localparam int DECAY  = 16;
  localparam int PH     = 256;
  localparam int PERIOD = 2 * PH;
  localparam int INF    = 1 << 30;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clkEn = 1'b0;
  logic        iRE = 1'b0;
  logic        iWE = 1'b0;
  logic [4:0]  iAddr = 5'h00;
  logic [7:0]  iDataW = 8'h00;
  logic [11:0] iOsc3 = 12'h000;
  logic [7:0]  iEnv3 = 8'h00;
  logic        iPotX = 1'b0;
  logic        iPotY = 1'b0;
  logic [7:0]  oDataR;
  logic        oPotDischarge;
  pot_state_e  dbg_state;

  sid_readback #(.DECAY_TICKS(DECAY), .POT_HALF(PH)) dut (
    .clk           (clk),
    .rst           (rst),
    .clkEn         (clkEn),
    .iRE           (iRE),
    .iWE           (iWE),
    .iAddr         (iAddr),
    .iDataW        (iDataW),
    .iOsc3         (iOsc3),
    .iEnv3         (iEnv3),
    .iPotX         (iPotX),
    .iPotY         (iPotY),
    .oDataR        (oDataR),
    .oPotDischarge (oPotDischarge),
    .oDbgState     (dbg_state)
  );

  always #5 clk = ~clk;

  // clkEn: one clk in four, changed just after the edge.
  int en_cnt = 0;
  always @(posedge clk) begin
    #1;
    en_cnt++;
    clkEn = (en_cnt % 4 == 0);
  end

  // tick_n = number of clkEn edges since reset release = index of next tick.
  int tick_n = 0;
  always @(posedge clk) begin
    if (rst) tick_n = 0;
    else if (clkEn) tick_n++;
  end

  // ---------------- reference model ----------------
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_exp = 8'h00;
  logic [7:0] latch_val = 8'h00;
  int         load_tick = 0;
  int         x_rise = INF;
  int         y_rise = INF;

  function automatic logic [7:0] latch_now();
    if (tick_n - load_tick >= DECAY) return 8'h00;
    return latch_val;
  endfunction

  // Value published by the most recent completed measurement period; rise is
  // the first tick at which the comparator is seen high (held high after).
  function automatic logic [7:0] pot_pub(input int rise);
    int p, start, d;
    if (tick_n < PERIOD) return 8'h00;
    p = tick_n / PERIOD - 1;
    start = p * PERIOD + PH;
    d = (rise <= start) ? 0 : rise - start;
    if (d > PH) d = PH;
    if (d > 255) d = 255;
    return 8'(d);
  endfunction

  function automatic logic [7:0] model_read(input logic [4:0] a);
    case (a)
      5'h19:   return pot_pub(x_rise);
      5'h1A:   return pot_pub(y_rise);
      5'h1B:   return iOsc3[11:4];
      5'h1C:   return iEnv3;
      default: return latch_now();
    endcase
  endfunction

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%02h exp=%02h", nm, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_read(input logic [4:0] a);
    logic [7:0] e;
    e = model_read(a);
    exp_q.push_back(e);
    last_exp  = e;
    latch_val = e;
    load_tick = tick_n + int'(clkEn);
    iAddr = a;
    iRE   = 1'b1;
    @(negedge clk);
    iRE = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    latch_val = d;
    load_tick = tick_n + int'(clkEn);
    iAddr  = a;
    iDataW = d;
    iWE    = 1'b1;
    @(negedge clk);
    iWE = 1'b0;
  endtask

  task automatic do_collide(input logic [4:0] a, input logic [7:0] d);
    latch_val = d;
    load_tick = tick_n + int'(clkEn);
    iAddr  = a;
    iDataW = d;
    iRE    = 1'b1;
    iWE    = 1'b1;
    @(negedge clk);
    iRE = 1'b0;
    iWE = 1'b0;
    check("collide_hold", oDataR, last_exp);
  endtask

  // Wait at negedges until tick_n (optionally modulo) equals target and,
  // if need_en, the coming edge is a clkEn edge.
  task automatic wait_tick(input string nm, input int target, input int modulus, input bit need_en);
    int budget;
    int v;
    budget = 20000;
    v = (modulus == 0) ? tick_n : tick_n % modulus;
    while (!(v == target && (!need_en || clkEn)) && budget > 0) begin
      @(negedge clk);
      budget--;
      v = (modulus == 0) ? tick_n : tick_n % modulus;
    end
    if (budget == 0) begin
      total++;
      bad++;
      $display("FAIL wait_%s got_tick=%0d exp_tick=%0d", nm, tick_n, target);
    end
  endtask

  task automatic reset_body();
    iRE = 1'b0;
    iWE = 1'b0;
    iPotX = 1'b0;
    iPotY = 1'b0;
    tick_n = 0;
    latch_val = 8'h00;
    load_tick = 0;
    x_rise = INF;
    y_rise = INF;
    last_exp = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tick_n = 0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin : monitor
    logic [7:0] e;
    if (!rst && iRE && !iWE) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL read_unexpected got=%02h exp=none", oDataR);
      end else begin
        e = exp_q.pop_front();
        check("read", oDataR, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [4:0] r_addr;
  logic [7:0] r_data;
  int         op;

  initial begin
    @(negedge clk);
    rst = 1'b1;
    reset_body();

    check("reset_rdata", oDataR, 8'h00);
    check("reset_discharge", {7'b0, oPotDischarge}, 8'h01);

    // reads after reset
    do_read(ADDR_POTX);
    do_read(ADDR_POTY);
    do_read(ADDR_OSC3);

    // OSC3 / ENV3
    iOsc3 = 12'hABC;
    iEnv3 = 8'h5A;
    do_read(ADDR_OSC3);
    do_read(ADDR_ENV3);

    // bus latch decay, including the tick just before expiry
    do_write(5'h04, 8'h3C);
    do_read(5'h04);
    wait_tick("decay15", load_tick + DECAY - 1, 0, 1'b0);
    do_read(5'h04);
    wait_tick("decay16", load_tick + DECAY, 0, 1'b0);
    do_read(5'h04);
    do_read(5'h04);

    // read/write collision, then write to a read-only address
    do_collide(ADDR_ENV3, 8'h77);
    do_read(5'h00);
    do_write(ADDR_OSC3, 8'h11);
    do_read(ADDR_OSC3);
    do_read(5'h00);

    // pot measurement: X rises 100 ticks into COUNT, Y stays low
    wait_tick("potx_rise", PH + 100, 0, 1'b0);
    check("count_discharge", {7'b0, oPotDischarge}, 8'h00);
    check("count_state", {7'b0, dbg_state}, 8'h01);
    iPotX  = 1'b1;
    x_rise = tick_n;
    do_read(ADDR_POTX);
    wait_tick("publish_edge", PERIOD - 1, 0, 1'b1);
    do_read(ADDR_POTX);
    do_read(ADDR_POTX);
    do_read(ADDR_POTY);
    check("after_publish_discharge", {7'b0, oPotDischarge}, 8'h01);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      iOsc3  = 12'($urandom_range(0, 4095));
      iEnv3  = 8'($urandom_range(0, 255));
      r_addr = 5'($urandom_range(0, 31));
      r_data = 8'($urandom_range(0, 255));
      op     = $urandom_range(0, 9);
      if (op < 6) do_read(r_addr);
      else if (op < 9) do_write(r_addr, r_data);
      else do_collide(r_addr, r_data);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(40, 90)) @(negedge clk);
      else repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // asynchronous reset 50 ticks into COUNT
    do_read(ADDR_POTY);
    wait_tick("mid_count", PH + 50, PERIOD, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_discharge", {7'b0, oPotDischarge}, 8'h01);
    check("rst_state", {7'b0, dbg_state}, 8'h00);
    check("rst_rdata", oDataR, 8'h00);
    reset_body();
    do_read(ADDR_POTX);
    do_read(ADDR_POTY);

    // first period after reset: Y rises 30 ticks into COUNT, X stays low
    wait_tick("poty_rise", PH + 30, 0, 1'b0);
    iPotY  = 1'b1;
    y_rise = tick_n;
    wait_tick("publish_edge2", PERIOD - 1, 0, 1'b1);
    do_read(ADDR_POTY);
    do_read(ADDR_POTX);
    do_read(ADDR_POTY);

    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_reads got=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sid_readback.md
# sid_readback

Read-side bus responder for the SID core: answers CPU reads of the 32-entry register space. It returns paddle (POTX/POTY), voice-2 oscillator (OSC3) and envelope (ENV3) values, and models the decaying data-bus latch for write-only addresses. It sits beside `sid_voices` on the same `iAddr` bus and is the counterpart to the voice write decoders.

## Interface
- `DECAY_TICKS`, 8192: `clkEn` ticks after the last bus activity before the bus latch clears to 0x00.
- `POT_HALF`, 256: `clkEn` ticks per pot phase (discharge, then count); must be ≤ 256.
- `clk` in 1: master clock.
- `rst` in 1: reset, asynchronous, active-high.
- `clkEn` in 1: 1 MHz tick enable.
- `iRE` in 1: read strobe, one `clk` wide.
- `iWE` in 1: write strobe, shared with the voice decoders.
- `iAddr` in 5: register address.
- `iDataW` in 8: write data, captured into the bus latch.
- `iOsc3` in 12: voice-2 waveform output; bits [11:4] form OSC3.
- `iEnv3` in 8: voice-2 envelope level.
- `iPotX`, `iPotY` in 1: asynchronous pot comparator outputs; 1 = capacitor above threshold.
- `oDataR` out 8: read data.
- `oPotDischarge` out 1: high while pot capacitors are being discharged.

## Operation
- Address map:
  - 0x19 returns POTX.
  - 0x1A returns POTY.
  - 0x1B returns `iOsc3[11:4]`, sampled on the read edge.
  - 0x1C returns `iEnv3`, sampled on the read edge.
  - 0x00–0x18 and 0x1D–0x1F return the bus latch.
- Bus latch (8 bit):
  - Loads `iDataW` on every `iWE`.
  - Loads the returned value on every serviced read.
  - Each load resets the decay counter to 0.
  - The decay counter increments on `clkEn` and saturates at `DECAY_TICKS`.
  - When the counter reaches `DECAY_TICKS`, the latch clears to 0x00 on that same edge.
- Pot FSM, advanced only on `clkEn`, with an 8-bit phase counter:
  - DISCHARGE: `oPotDischarge`=1; both pot counts cleared. After `POT_HALF` ticks, go to COUNT with the phase counter reset to 0.
  - COUNT: `oPotDischarge`=0. Each axis count increments by one per tick while its synchronized input is 0 and it is not yet stopped. The first tick that sees input 1 sets that axis's stop flag. Counts saturate at 255. After `POT_HALF` ticks, publish both counts into POTX/POTY and go to DISCHARGE.
- `iPotX`/`iPotY` pass through 2-flop synchronizers on `clk`.
- Simultaneous `iRE` and `iWE`: the write wins. The read is dropped, `oDataR` holds, and the latch loads `iDataW`.
- Write to a read-only address (0x19–0x1C): loads the latch only; POT/OSC3/ENV3 are unaffected.

## Timing
- Reset values:
  - `oDataR`=0x00, bus latch=0x00, decay counter=0.
  - POTX=POTY=0x00, state=DISCHARGE, phase counter=0, `oPotDischarge`=1.
  - Synchronizers=0.
- Read latency: `oDataR` updates on the `clk` edge where `iRE`=1 and is valid the following cycle. It holds until the next serviced read. Reads are not gated by `clkEn`.
- POTX/POTY update once per 2×`POT_HALF` `clkEn` ticks, at the COUNT→DISCHARGE edge. A read on that same edge returns the old value.
- Pot input to count effect: 2 `clk` (synchronizer), then the next `clkEn`.
- Phase counter wrap: the terminal tick is `POT_HALF`−1. No tick is lost at state changes.
- `rst` mid-COUNT: partial counts are discarded; the FSM restarts in DISCHARGE at the phase counter's first tick.
- Latch load and decay expiry on the same edge: the load wins.

## Structure
- Shared package `sid_pkg` holds:
  - Address constants `ADDR_POTX`=0x19, `ADDR_POTY`=0x1A, `ADDR_OSC3`=0x1B, `ADDR_ENV3`=0x1C.
  - The pot FSM state enum (DISCHARGE, COUNT).
- Sub-module `sid_pot_axis`, instantiated twice, contains:
  - Synchronizer.
  - Stop flag.
  - Saturating 8-bit count.
  - Published register.
- The FSM, phase counter, decay logic and read mux stay in `sid_readback`.

## Test plan
- Read after reset: read 0x19, 0x1A, 0x1B while `iOsc3`=0, `iEnv3`=0 -> `oDataR`=0x00 each, one cycle after `iRE`. Also `oPotDischarge`=1.
- OSC3/ENV3: `iOsc3`=0xABC, `iEnv3`=0x5A, read 0x1B then 0x1C -> 0xAB, then 0x5A.
- Pot count: `iPotX` rises 100 `clkEn` ticks into COUNT; `iPotY` held 0 -> after the phase, POTX=100 and POTY=255.
- Bus decay, with `DECAY_TICKS`=16:
  - Write 0x3C to 0x04, then read 0x04 -> 0x3C.
  - Wait 16 `clkEn` ticks, read 0x04 -> 0x00.
  - Read 0x04 again -> 0x00.
- Collision: `iRE`+`iWE` same cycle, addr 0x1C, data 0x77 -> `oDataR` unchanged. A later read of 0x00 returns 0x77.
- Async reset mid-COUNT (tick 50): assert `rst` between `clk` edges -> `oPotDischarge`=1 immediately and POTX/POTY=0x00. After release, the first publish occurs 2×`POT_HALF` ticks later.
